// File: rtl/exa_crosb_output_vc_scheduler.sv
// Output-port VC scheduler: strict priority across levels, round-robin across VCs,
// per-queue downstream credit tracking and packet-granular grant holding.
module exa_crosb_output_vc_scheduler #(
  parameter int unsigned prio_num   = 2,
  parameter int unsigned vc_num     = 2,
  parameter int unsigned credit_max = 8,
  localparam int unsigned nq    = prio_num * vc_num,
  localparam int unsigned log_q = (nq > 1) ? $clog2(nq) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nq-1:0]    i_req,
  input  logic             i_flit_valid,
  input  logic             i_flit_last,
  input  logic             i_credit_valid,
  input  logic [log_q-1:0] i_credit_idx,
  output logic [nq-1:0]    o_grant,
  output logic [log_q-1:0] o_grant_idx,
  output logic             o_cts,
  output logic [nq-1:0]    o_credit_avail,
  output logic             o_err
);

  localparam int unsigned cw = $clog2(credit_max + 1);
  localparam int unsigned vw = (vc_num > 1) ? $clog2(vc_num) : 1;
  localparam int unsigned pw = (prio_num > 1) ? $clog2(prio_num) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state, state_nxt;
  logic [cw-1:0]    credit     [nq];
  logic [cw-1:0]    credit_nxt [nq];
  logic [vw-1:0]    rr_ptr     [prio_num];
  logic [vw-1:0]    rr_nxt     [prio_num];
  logic [nq-1:0]    grant_nxt;
  logic [log_q-1:0] grant_idx_nxt;
  logic             err_nxt;
  logic [nq-1:0]    eligible;
  logic             win_found;
  logic [log_q-1:0] win_idx;
  logic [vw-1:0]    win_vc;
  logic [pw-1:0]    win_prio;
  logic             flit_ok;

  always_comb begin
    for (int q = 0; q < int'(nq); q++) o_credit_avail[q] = (credit[q] != '0);
  end

  assign eligible = i_req & o_credit_avail;
  assign o_cts    = (state == GRANTED) && (credit[o_grant_idx] != '0);

  // Highest priority level with an eligible queue wins; VCs scanned from rr_ptr+1.
  always_comb begin
    int sel;
    sel       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_vc    = '0;
    win_prio  = '0;
    for (int p = int'(prio_num) - 1; p >= 0; p--) begin
      for (int k = 1; k <= int'(vc_num); k++) begin
        sel = (int'(rr_ptr[p]) + k) % int'(vc_num);
        if (!win_found && eligible[p*int'(vc_num) + sel]) begin
          win_found = 1'b1;
          win_idx   = log_q'(p*int'(vc_num) + sel);
          win_vc    = vw'(sel);
          win_prio  = pw'(p);
        end
      end
    end
  end

  always_comb begin
    logic dec, inc;
    state_nxt     = state;
    grant_nxt     = o_grant;
    grant_idx_nxt = o_grant_idx;
    rr_nxt        = rr_ptr;
    err_nxt       = o_err;
    credit_nxt    = credit;
    flit_ok       = 1'b0;
    dec           = 1'b0;
    inc           = 1'b0;

    case (state)
      IDLE: begin
        if (i_flit_valid) err_nxt = 1'b1;
        if (win_found) begin
          state_nxt          = GRANTED;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          grant_idx_nxt      = win_idx;
          rr_nxt[win_prio]   = win_vc;
        end
      end
      GRANTED: begin
        if (i_flit_valid) begin
          if (o_cts) flit_ok = 1'b1;
          else       err_nxt = 1'b1;
          if (i_flit_last) begin
            state_nxt     = IDLE;
            grant_nxt     = '0;
            grant_idx_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Simultaneous return and accepted flit on one queue cancel out.
    for (int q = 0; q < int'(nq); q++) begin
      dec = flit_ok && (int'(o_grant_idx) == q);
      inc = i_credit_valid && (int'(i_credit_idx) == q);
      if (inc && !dec) begin
        if (credit[q] == cw'(credit_max)) err_nxt = 1'b1;
        else                              credit_nxt[q] = credit[q] + cw'(1);
      end else if (dec && !inc) begin
        credit_nxt[q] = credit[q] - cw'(1);
      end
    end
    if (i_credit_valid && (int'(i_credit_idx) >= int'(nq))) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      o_grant     <= '0;
      o_grant_idx <= '0;
      o_err       <= 1'b0;
      for (int q = 0; q < int'(nq); q++)       credit[q] <= cw'(credit_max);
      for (int p = 0; p < int'(prio_num); p++) rr_ptr[p] <= vw'(vc_num - 1);
    end else begin
      state       <= state_nxt;
      o_grant     <= grant_nxt;
      o_grant_idx <= grant_idx_nxt;
      o_err       <= err_nxt;
      for (int q = 0; q < int'(nq); q++)       credit[q] <= credit_nxt[q];
      for (int p = 0; p < int'(prio_num); p++) rr_ptr[p] <= rr_nxt[p];
    end
  end

endmodule
